// File: rtl/btn_debounce.sv
// btn_debounce: synchronises, debounces and edge-detects N_BTN pushbuttons on a strobe taken from clkdiv.
// Define BTN_AUTOREPEAT_EN to add hold-to-repeat press pulses (REPEAT_DELAY / REPEAT_PERIOD ticks).
module btn_debounce #(
   parameter int N_BTN          = 5,
   parameter int TICK_BIT       = 17,
   parameter int STABLE_CNT     = 4,
   parameter int BTN_ACTIVE_LOW = 0,
   parameter int REPEAT_DELAY   = 32,
   parameter int REPEAT_PERIOD  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      clkdiv,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_out,
   output logic [N_BTN-1:0] btn_pos,
   output logic [N_BTN-1:0] btn_neg,
   output logic             tick
);

   localparam int              CW       = $clog2(STABLE_CNT + 1);
   localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_CNT - 1);
   localparam logic [N_BTN-1:0] POL_MASK = {N_BTN{BTN_ACTIVE_LOW != 0}};

   if (N_BTN < 1 || TICK_BIT < 0 || TICK_BIT > 31 || STABLE_CNT < 1 ||
       REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
      $error("btn_debounce: illegal parameter value");
   end

   logic [N_BTN-1:0] sync_q1;
   logic [N_BTN-1:0] sync_q2;
   logic [N_BTN-1:0] s;
   logic             tick_prev;
   logic [CW-1:0]    cnt [N_BTN];
   logic [N_BTN-1:0] accept;
   logic [N_BTN-1:0] rep_fire;
   logic             unused_clkdiv;

   // Only one clkdiv bit matters; the rest of the bus is consumed here on purpose.
   assign unused_clkdiv = ^clkdiv;

   // Sync flops reset to the idle pin level so an active-low board does not see a phantom press.
   // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q1 <= POL_MASK;
         sync_q2 <= POL_MASK;
      end else begin
         sync_q1 <= btn_raw;
         sync_q2 <= sync_q1;
      end
   end

   assign s = sync_q2 ^ POL_MASK;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) tick_prev <= 1'b0;
      else      tick_prev <= clkdiv[TICK_BIT];
   end

   // Gated by rst so the strobe stays low while the block is held in reset.
   assign tick = rst & clkdiv[TICK_BIT] & ~tick_prev;

   for (genvar i = 0; i < N_BTN; i++) begin : g_accept
      assign accept[i] = tick & (s[i] != btn_out[i]) & (cnt[i] == CNT_LAST);
   end

   // NOTE: cnt is a small flop array, not a RAM, so it is reset like any other register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
      end else if (tick) begin
         for (int i = 0; i < N_BTN; i++) begin
            if (s[i] == btn_out[i] || accept[i]) cnt[i] <= '0;
            else                                 cnt[i] <= cnt[i] + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         btn_out <= '0;
         btn_pos <= '0;
         btn_neg <= '0;
      end else begin
         btn_out <= btn_out ^ accept;
         btn_pos <= (accept & s) | rep_fire;
         btn_neg <= accept & ~s;
      end
   end

`ifdef BTN_AUTOREPEAT_EN
   localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int HW   = $clog2(HMAX + 1);
   localparam logic [HW-1:0] REP_DELAY  = HW'(REPEAT_DELAY);
   localparam logic [HW-1:0] REP_PERIOD = HW'(REPEAT_PERIOD);

   // hold_rep selects the target: first REPEAT_DELAY ticks, then REPEAT_PERIOD ticks per repeat.
   for (genvar i = 0; i < N_BTN; i++) begin : g_repeat
      logic [HW-1:0] hold_cnt;
      logic [HW-1:0] hold_nxt;
      logic          hold_rep;

      assign hold_nxt    = hold_cnt + HW'(1);
      assign rep_fire[i] = tick & btn_out[i] & ~accept[i] &
                           (hold_nxt == (hold_rep ? REP_PERIOD : REP_DELAY));

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            hold_cnt <= '0;
            hold_rep <= 1'b0;
         end else if (!btn_out[i] || accept[i]) begin
            hold_cnt <= '0;
            hold_rep <= 1'b0;
         end else if (rep_fire[i]) begin
            hold_cnt <= '0;
            hold_rep <= 1'b1;
         end else if (tick) begin
            hold_cnt <= hold_nxt;
         end
      end
   end
`else
   assign rep_fire = '0;
`endif

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Debounces and edge-detects board pushbuttons (N_BTN lines) for the CPU/IO top level.
- Sits directly downstream of the clock divider. It consumes the free-running clkdiv bus and derives its sample strobe from one clkdiv bit.
- Outputs are used by the CPU single-step / IO logic:
  - clean levels;
  - one-clk press/release pulses.
- Fully synchronous to clk; no derived clocks.

Parameters:
N_BTN, 5, number of button lines
TICK_BIT, 17, clkdiv bit whose rising edge is the sample strobe (0..31)
STABLE_CNT, 4, consecutive disagreeing samples required to accept a change (>=1)
BTN_ACTIVE_LOW, 0, 1 = raw buttons read 0 when pressed (inverted at input)
REPEAT_DELAY, 32, ticks held before first auto-repeat (optional feature only)
REPEAT_PERIOD, 8, ticks between auto-repeats (optional feature only)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
clkdiv  input  32  free-running divider count from the clock divider
btn_raw  input  N_BTN  asynchronous raw button pins
btn_out  output  N_BTN  debounced level, 1 = pressed
btn_pos  output  N_BTN  one-clk pulse on accepted press (and auto-repeat)
btn_neg  output  N_BTN  one-clk pulse on accepted release
tick  output  1  sample strobe, one clk wide

Behaviour:
- Reset (rst=0, async): all registers cleared; btn_out, btn_pos, btn_neg, tick = 0.
- Synchroniser: btn_raw passes through 2 clk flops, then optional inversion (BTN_ACTIVE_LOW) -> s[i]. Raw-to-s latency is 2 clk.
- Strobe: prev <= clkdiv[TICK_BIT] every clk; tick = clkdiv[TICK_BIT] & ~prev (combinational).
  - prev resets to 0, so one spurious tick may occur in the first cycle after reset; this is accepted.
  - No tick is generated on clkdiv wrap unless the bit rises.
- Per-button counter cnt[i], width $clog2(STABLE_CNT+1). Updated only on clk edges where tick=1:
  - s[i]==btn_out[i]: cnt<=0.
  - s[i]!=btn_out[i] and cnt==STABLE_CNT-1: btn_out[i]<=s[i], cnt<=0.
  - otherwise: cnt<=cnt+1.
  - Net effect: a change is accepted on the STABLE_CNT-th consecutive disagreeing tick. Any agreeing tick in between (a bounce) restarts the count.
- Pulses are registered on the same edge that updates btn_out:
  - btn_pos[i]=1 for exactly one clk when btn_out[i] goes 0->1.
  - btn_neg[i]=1 for exactly one clk when btn_out[i] goes 1->0.
  - Both are 0 on every other cycle, including non-tick cycles.
- Buttons are independent. Simultaneous changes on several lines produce simultaneous pulses.
- STABLE_CNT=1: change accepted on the first disagreeing tick.
- Reset mid-bounce: counters clear, and btn_out returns to 0 with no btn_neg pulse.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined:
  - Per button, a hold counter (width for max(REPEAT_DELAY,REPEAT_PERIOD)) counts ticks while btn_out[i]=1.
  - A btn_pos pulse is emitted after REPEAT_DELAY ticks, then every REPEAT_PERIOD ticks.
  - The counter clears when btn_out[i]=0 or on reset. Auto-repeat pulses are one clk wide.
- Undefined: no hold counters are built; btn_pos fires only on accepted press; REPEAT_* are ignored.

Test Plan:
- All tests use TICK_BIT=2 (tick every 8 clk), STABLE_CNT=4, N_BTN=2.
- Reset: hold rst=0 with btn_raw=2'b11 -> btn_out=0, btn_pos=0, btn_neg=0. Release rst, drive clkdiv from a counter -> tick pulses every 8 clk, one clk wide.
- Clean press: btn_raw[0] 0->1 held -> btn_out[0]=1 on the 4th tick after s[0] rises; btn_pos[0] high exactly 1 clk on that edge; btn_out[1] stays 0.
- Bounce: btn_raw[0]=1 for 3 ticks, 0 for 1 tick, then 1 steady -> no change after the first 3 ticks; btn_out[0] rises 4 ticks after the final rise; only one btn_pos.
- Release plus simultaneous lines: both pressed, then both released together -> btn_neg=2'b11 for 1 clk on the same edge; btn_out=0.
- Reset mid-count: after 2 disagreeing ticks, pulse rst=0 -> cnt cleared. With input still high after release, a press needs 4 fresh ticks; no pulses occur during reset.
- BTN_AUTOREPEAT_EN defined, REPEAT_DELAY=6, REPEAT_PERIOD=2, hold press -> btn_pos pulses at accept, +6 ticks, then every 2 ticks. On release, repeats stop and one btn_neg is seen.
